dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter that shares the single-port data memory between port 0 (CPU load/store) and port 1 (DMA/debug loader). The memory has a combinational read and writes on the falling clock edge.
- The arbiter owns the memory-side address, write-data and write-enable signals.
- It grants one port at a time, with round-robin fairness and a bounded burst tenure.
- It returns registered read data to the requester.

Parameters:
ADDR_W, 32, address width of ports and memory side
DATA_W, 32, data width
MAX_BURST, 4, max consecutive granted beats for one owner while the other port is requesting (>=1)

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 access request, held until granted
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 address
p0_wdata  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 beat accepted this cycle
p0_rvalid  out  1  port 0 read data valid (1-cycle pulse)
p0_rdata  out  DATA_W  port 0 read data
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata  same as port 0, for port 1
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rw  out  1  memory write enable (1 = write)
mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Reset: IDLE, last_owner=1 (port 0 wins first), beat_cnt=0, all pX_rvalid/pX_rdata=0.
- IDLE: no port granted; mem_addr=0, mem_wdata=0, mem_rw=0.
  - Only one req high: next state is OWN of that port.
  - Both high: next state is OWN of the port != last_owner.
  - IDLE always costs one cycle (arbitration bubble).
- OWNx: pX_gnt = pX_req (combinational).
  - mem_addr/mem_wdata mux from port x every cycle in OWNx.
  - mem_rw = pX_req & pX_we.
  - The non-owner's gnt is 0.
- Beat: a cycle with pX_gnt=1. Each beat increments beat_cnt; last_owner<=x.
- Read beat: at the rising edge ending the beat, pX_rdata<=mem_rdata and pX_rvalid<=1 for exactly one cycle. Read latency = 1 cycle after gnt.
- Write beat: the memory commits on the falling edge inside the beat. pX_rvalid stays 0 and pX_rdata holds its value.
- OWNx transitions, evaluated each rising edge:
  - Owner req low: go to OWNy if the other port's req is high, else IDLE; beat_cnt<=0.
  - Beat with beat_cnt==MAX_BURST-1 and the other port's req high: go to OWNy directly, no bubble; beat_cnt<=0.
  - Beat with beat_cnt==MAX_BURST-1 and the other port's req low: stay; beat_cnt<=0 (tenure renewed).
  - Otherwise stay.
- Handover OWNx->OWNy takes no idle cycle. Port y's first beat is the cycle after port x's last beat.
- A request dropped in a cycle while owned is not a beat; no memory access occurs.
- Simultaneous requests at reset release: port 0 granted first.
- Reset mid-operation: async clear forces IDLE immediately. gnt and mem_rw drop combinationally, so a write whose falling edge has not yet occurred is suppressed. Pending rvalid is cleared.
- Starvation bound: a continuously requesting port waits at most MAX_BURST beats + 1 cycle.

Test Plan:
- Reset, then p0 read of addr 0x10 (mem holds 0xDEADBEEF). Required: IDLE cycle, then p0_gnt=1; next cycle p0_rvalid=1 with p0_rdata=0xDEADBEEF; mem_rw stays 0.
- p1 write 0x12345678 to addr 0x20, then p1 read of 0x20. Required: mem_rw=1 only in the write gnt cycle; the read returns 0x12345678 one cycle after its gnt.
- Both req held from reset, MAX_BURST=4. Required: p0 gets beats 1-4, then p1 gets 4 beats with no bubble, then p0 again; p0_gnt and p1_gnt never high together.
- p0 streaming 10 reads, p1 idle. Required: 10 consecutive p0 beats after one IDLE cycle, no bubbles at beat 4 or 8.
- p0 drops req mid-tenure while p1 requests. Required: the next cycle is OWN1 with p1_gnt=1; beat_cnt restarts at 0.
- rst_n asserted low during a p1 write cycle before the falling edge. Required: p1_gnt, mem_rw and p1_rvalid go 0 immediately, memory is unchanged, and state is IDLE after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for a single-port data memory.
// Port 0 (CPU) and port 1 (DMA/debug) share the memory. Ownership is
// round-robin, and each tenure lasts at most MAX_BURST beats while the
// other port waits. Read data is returned one cycle after the grant,
// through a register.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_rdata
);

  // A 1-bit counter still works when MAX_BURST is 1 (every beat is the last).
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_r;
  logic              last_owner_r;
  logic [CNT_W-1:0]  beat_cnt_r;
  logic              p0_rvalid_r;
  logic              p1_rvalid_r;
  logic [DATA_W-1:0] p0_rdata_r;
  logic [DATA_W-1:0] p1_rdata_r;

  logic              gnt0_s;
  logic              gnt1_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              rw_s;

  // Grant and memory-side mux. These follow the state register combinationally, so an
  // async reset drops the grant and the write enable before the falling-edge commit.
  always_comb begin
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    addr_s  = '0;
    wdata_s = '0;
    rw_s    = 1'b0;
    case (state_r)
      OWN0: begin
        gnt0_s  = p0_req;
        addr_s  = p0_addr;
        wdata_s = p0_wdata;
        rw_s    = p0_req & p0_we;
      end
      OWN1: begin
        gnt1_s  = p1_req;
        addr_s  = p1_addr;
        wdata_s = p1_wdata;
        rw_s    = p1_req & p1_we;
      end
      default: begin
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        addr_s  = '0;
        wdata_s = '0;
        rw_s    = 1'b0;
      end
    endcase
  end

  // Ownership FSM: round-robin from IDLE, direct handover at burst end or on a dropped request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_owner_r <= 1'b1;
      beat_cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          beat_cnt_r <= '0;
          if (p0_req && p1_req) begin
            state_r <= last_owner_r ? OWN0 : OWN1;
          end else if (p0_req) begin
            state_r <= OWN0;
          end else if (p1_req) begin
            state_r <= OWN1;
          end else begin
            state_r <= IDLE;
          end
        end
        OWN0: begin
          if (!p0_req) begin
            state_r    <= p1_req ? OWN1 : IDLE;
            beat_cnt_r <= '0;
          end else begin
            last_owner_r <= 1'b0;
            if (beat_cnt_r == LAST_BEAT) begin
              beat_cnt_r <= '0;
              state_r    <= p1_req ? OWN1 : OWN0;
            end else begin
              beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
          end
        end
        OWN1: begin
          if (!p1_req) begin
            state_r    <= p0_req ? OWN0 : IDLE;
            beat_cnt_r <= '0;
          end else begin
            last_owner_r <= 1'b1;
            if (beat_cnt_r == LAST_BEAT) begin
              beat_cnt_r <= '0;
              state_r    <= p0_req ? OWN0 : OWN1;
            end else begin
              beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end

  // Read return: capture memory data at the end of a read beat and pulse rvalid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= '0;
      p1_rdata_r  <= '0;
    end else begin
      p0_rvalid_r <= gnt0_s & ~p0_we;
      p1_rvalid_r <= gnt1_s & ~p1_we;
      if (gnt0_s && !p0_we) begin
        p0_rdata_r <= mem_rdata;
      end else begin
        p0_rdata_r <= p0_rdata_r;
      end
      if (gnt1_s && !p1_we) begin
        p1_rdata_r <= mem_rdata;
      end else begin
        p1_rdata_r <= p1_rdata_r;
      end
    end
  end

  assign p0_gnt    = gnt0_s;
  assign p1_gnt    = gnt1_s;
  assign mem_addr  = addr_s;
  assign mem_wdata = wdata_s;
  assign mem_rw    = rw_s;
  assign p0_rvalid = p0_rvalid_r;
  assign p1_rvalid = p1_rvalid_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_rdata  = p1_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a read-data scoreboard.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata, p1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_rw;

  logic [DATA_W-1:0] mem     [0:255];
  logic [DATA_W-1:0] ref_mem [0:255];
  logic [DATA_W-1:0] q0 [$];
  logic [DATA_W-1:0] q1 [$];
  logic [DATA_W-1:0] mon_e;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on the falling edge.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(negedge clk) begin
    if (mem_rw) mem[mem_addr[7:0]] = mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected read data queued at each read beat, compared on the following cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      chk("gnt_excl", {63'd0, p0_gnt & p1_gnt}, 64'd0);
      chk("mem_rw_mon", {63'd0, mem_rw}, {63'd0, (p0_gnt & p0_we) | (p1_gnt & p1_we)});
      chk("p0_rvalid_mon", {63'd0, p0_rvalid}, {63'd0, q0.size() > 0});
      if (q0.size() > 0) begin
        mon_e = q0.pop_front();
        chk("p0_rdata_mon", {32'd0, p0_rdata}, {32'd0, mon_e});
      end
      chk("p1_rvalid_mon", {63'd0, p1_rvalid}, {63'd0, q1.size() > 0});
      if (q1.size() > 0) begin
        mon_e = q1.pop_front();
        chk("p1_rdata_mon", {32'd0, p1_rdata}, {32'd0, mon_e});
      end
      if (p0_gnt && !p0_we) q0.push_back(ref_mem[p0_addr[7:0]]);
      if (p0_gnt && p0_we) ref_mem[p0_addr[7:0]] = p0_wdata;
      if (p1_gnt && !p1_we) q1.push_back(ref_mem[p1_addr[7:0]]);
      if (p1_gnt && p1_we) ref_mem[p1_addr[7:0]] = p1_wdata;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    mem[16]     = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'd0; p0_wdata = 32'd0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'd0; p1_wdata = 32'd0;

    // Reset state
    tick();
    chk("rst_p0_gnt", {63'd0, p0_gnt}, 64'd0);
    chk("rst_p1_gnt", {63'd0, p1_gnt}, 64'd0);
    chk("rst_p0_rvalid", {63'd0, p0_rvalid}, 64'd0);
    chk("rst_p1_rdata", {32'd0, p1_rdata}, 64'd0);
    chk("rst_mem_rw", {63'd0, mem_rw}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    tick();
    rst_n = 1'b1;

    // p0 read of 0x10
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    #1 chk("t1_idle_gnt", {63'd0, p0_gnt}, 64'd0);
    tick();
    chk("t1_gnt", {63'd0, p0_gnt}, 64'd1);
    chk("t1_addr", {32'd0, mem_addr}, 64'h10);
    chk("t1_rw", {63'd0, mem_rw}, 64'd0);
    tick();
    chk("t1_rvalid", {63'd0, p0_rvalid}, 64'd1);
    chk("t1_rdata", {32'd0, p0_rdata}, 64'hDEAD_BEEF);
    p0_req = 1'b0;
    #1 chk("t1_drop_gnt", {63'd0, p0_gnt}, 64'd0);
    tick();
    chk("t1_rvalid_pulse", {63'd0, p0_rvalid}, 64'd0);

    // p1 write then read of 0x20
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h1234_5678;
    #1 chk("t2_idle_gnt", {63'd0, p1_gnt}, 64'd0);
    tick();
    chk("t2_wr_gnt", {63'd0, p1_gnt}, 64'd1);
    chk("t2_wr_rw", {63'd0, mem_rw}, 64'd1);
    chk("t2_wr_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
    tick();
    chk("t2_mem", {32'd0, mem[32]}, 64'h1234_5678);
    p1_we = 1'b0;
    #1 chk("t2_rd_gnt", {63'd0, p1_gnt}, 64'd1);
    chk("t2_rd_rw", {63'd0, mem_rw}, 64'd0);
    chk("t2_wr_no_rvalid", {63'd0, p1_rvalid}, 64'd0);
    tick();
    chk("t2_rvalid", {63'd0, p1_rvalid}, 64'd1);
    chk("t2_rdata", {32'd0, p1_rdata}, 64'h1234_5678);
    p1_req = 1'b0;
    tick();

    // Both requesting from reset: p0 x4, p1 x4, p0 x4
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h30;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h40;
    tick();
    rst_n = 1'b1;
    #1 chk("t3_idle0", {63'd0, p0_gnt}, 64'd0);
    chk("t3_idle1", {63'd0, p1_gnt}, 64'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("t3_p0_gnt_%0d", i), {63'd0, p0_gnt}, {63'd0, ((i / 4) % 2) == 0});
      chk($sformatf("t3_p1_gnt_%0d", i), {63'd0, p1_gnt}, {63'd0, ((i / 4) % 2) == 1});
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    tick();

    // p0 streams 10 reads, p1 idle
    rst_n = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h50;
    tick();
    rst_n = 1'b1;
    #1 chk("t4_idle", {63'd0, p0_gnt}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      p0_addr = 32'h50 + 32'(i);
      #1 chk($sformatf("t4_gnt_%0d", i), {63'd0, p0_gnt}, 64'd1);
    end
    p0_req = 1'b0;
    tick();
    tick();

    // p0 drops mid-tenure while p1 waits; p1 then gets a full fresh tenure
    rst_n = 1'b0;
    p0_req = 1'b1; p0_addr = 32'h70;
    p1_addr = 32'h71;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_p0_b1", {63'd0, p0_gnt}, 64'd1);
    tick();
    p1_req = 1'b1;
    #1 chk("t5_p0_b2", {63'd0, p0_gnt}, 64'd1);
    chk("t5_p1_wait", {63'd0, p1_gnt}, 64'd0);
    tick();
    p0_req = 1'b0;
    #1 chk("t5_drop_p0", {63'd0, p0_gnt}, 64'd0);
    chk("t5_drop_p1", {63'd0, p1_gnt}, 64'd0);
    chk("t5_drop_rw", {63'd0, mem_rw}, 64'd0);
    tick();
    chk("t5_p1_b1", {63'd0, p1_gnt}, 64'd1);
    p0_req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("t5_p1_b%0d", j + 2), {63'd0, p1_gnt}, 64'd1);
      chk($sformatf("t5_p0_wait%0d", j), {63'd0, p0_gnt}, 64'd0);
    end
    tick();
    chk("t5_p0_back", {63'd0, p0_gnt}, 64'd1);
    chk("t5_p1_off", {63'd0, p1_gnt}, 64'd0);
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    tick();

    // Async reset during a p1 write, before the falling edge
    rst_n = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h60;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_rd_gnt", {63'd0, p1_gnt}, 64'd1);
    tick();
    p1_we = 1'b1; p1_addr = 32'h61; p1_wdata = 32'hCAFE_F00D;
    #1 chk("t6_wr_gnt", {63'd0, p1_gnt}, 64'd1);
    chk("t6_wr_rw", {63'd0, mem_rw}, 64'd1);
    chk("t6_rvalid_pend", {63'd0, p1_rvalid}, 64'd1);
    rst_n = 1'b0;
    #1 chk("t6_rst_gnt", {63'd0, p1_gnt}, 64'd0);
    chk("t6_rst_rw", {63'd0, mem_rw}, 64'd0);
    chk("t6_rst_rvalid", {63'd0, p1_rvalid}, 64'd0);
    @(negedge clk);
    #1 chk("t6_mem_kept", {32'd0, mem[97]}, 64'hA500_0061);
    tick();
    rst_n = 1'b1;
    p1_we = 1'b0;
    #1 chk("t6_idle_gnt", {63'd0, p1_gnt}, 64'd0);
    tick();
    chk("t6_regrant", {63'd0, p1_gnt}, 64'd1);
    p1_req = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
